// File: rtl/poly_mix_sampler.sv
// poly_mix_sampler: shared sample strobe, per-voice gain/pan MAC,
// 16-bit stereo saturation and one I2S frame push per sample.
module poly_mix_sampler #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_DIV = 8,
    parameter int GAIN_W     = 8
) (
    input  logic                         clk,
    input  logic                         aclr,
    input  logic                         enable,
    input  logic [16*NUM_VOICES-1:0]     voice_sample,
    input  logic [GAIN_W*NUM_VOICES-1:0] voice_gain,
    input  logic [2*NUM_VOICES-1:0]      voice_pan,
    input  logic                         clip_clr,
    input  logic                         wrfull,
    output logic                         clk_sample,
    output logic                         wrreq,
    output logic [63:0]                  lrsample,
    output logic                         clip,
    output logic                         busy
);

    localparam int CNT_W  = $clog2(NUM_VOICES + 1);
    localparam int NSLOT  = 1 << CNT_W;
    localparam int PROD_W = 16 + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_VOICES);
    localparam int DIV_W  = $clog2(SAMPLE_DIV);

    localparam logic [DIV_W-1:0]        DIV_TC   = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(NUM_VOICES);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-32768);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        SAT,
        OUT
    } state_t;

    state_t                    state_q, state_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_l_q, acc_l_d;
    logic signed [ACC_W-1:0]   acc_r_q, acc_r_d;
    logic                      strobe_q, strobe_d;
    logic [63:0]               lr_q, lr_d;
    logic                      clip_q, clip_d;

    logic                      fire;
    logic                      term;

    logic signed [15:0]        samp_a [NSLOT];
    logic [GAIN_W-1:0]         gain_a [NSLOT];
    logic [1:0]                pan_a  [NSLOT];

    logic [CNT_W-1:0]          vsel;
    logic signed [15:0]        samp_sel;
    logic [GAIN_W-1:0]         gain_sel;
    logic [1:0]                pan_sel;
    logic signed [PROD_W-1:0]  prod;

    logic signed [ACC_W-1:0]   sh_l, sh_r;
    logic [15:0]               sat_l, sat_r;
    logic                      clp_l, clp_r;

    // Unpack the flat voice buses into indexable slots; spare slots read zero.
    generate
        for (genvar g = 0; g < NSLOT; g++) begin : g_slot
            if (g < NUM_VOICES) begin : g_voice
                assign samp_a[g] = voice_sample[16*g +: 16];
                assign gain_a[g] = voice_gain[GAIN_W*g +: GAIN_W];
                assign pan_a[g]  = voice_pan[2*g +: 2];
            end else begin : g_spare
                assign samp_a[g] = '0;
                assign gain_a[g] = '0;
                assign pan_a[g]  = '0;
            end
        end
    endgenerate

    // Sample divider: strobe only from IDLE, otherwise park at terminal count.
    always_comb begin
        term     = (div_q == DIV_TC);
        fire     = enable && !wrfull && term && (state_q == IDLE);
        div_d    = div_q;
        strobe_d = fire;
        if (!enable) begin
            div_d = '0;
        end else if (fire) begin
            div_d = '0;
        end else if (!wrfull && !term) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Voice select and signed gain product; count 0 is the settle cycle.
    always_comb begin
        vsel     = cnt_q - CNT_W'(1);
        samp_sel = samp_a[vsel];
        gain_sel = gain_a[vsel];
        pan_sel  = pan_a[vsel];
        prod     = PROD_W'(samp_sel) * PROD_W'($signed({1'b0, gain_sel}));
    end

    // Drop the gain fraction (floor) and clamp each channel to 16 bits.
    always_comb begin
        sh_l  = acc_l_q >>> GAIN_W;
        sh_r  = acc_r_q >>> GAIN_W;
        clp_l = 1'b0;
        clp_r = 1'b0;
        sat_l = sh_l[15:0];
        sat_r = sh_r[15:0];
        if (sh_l > SAT_MAX) begin
            sat_l = 16'h7FFF;
            clp_l = 1'b1;
        end else if (sh_l < SAT_MIN) begin
            sat_l = 16'h8000;
            clp_l = 1'b1;
        end
        if (sh_r > SAT_MAX) begin
            sat_r = 16'h7FFF;
            clp_r = 1'b1;
        end else if (sh_r < SAT_MIN) begin
            sat_r = 16'h8000;
            clp_r = 1'b1;
        end
    end

    // Frame FSM: accumulate voices, saturate, then push one FIFO word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        lr_d    = lr_q;
        clip_d  = clip_q && !clip_clr;
        wrreq   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = ACC;
                    cnt_d   = '0;
                    acc_l_d = '0;
                    acc_r_d = '0;
                end
            end
            ACC: begin
                if (cnt_q != '0) begin
                    if (!pan_sel[1]) begin
                        acc_l_d = acc_l_q + ACC_W'(prod);
                    end
                    if (!pan_sel[0]) begin
                        acc_r_d = acc_r_q + ACC_W'(prod);
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = SAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAT: begin
                lr_d    = {16'h0000, sat_r, 16'h0000, sat_l};
                state_d = OUT;
                if (clp_l || clp_r) begin
                    clip_d = 1'b1;
                end
            end
            OUT: begin
                if (!wrfull) begin
                    wrreq   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; aclr abandons any frame in flight.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            strobe_q <= 1'b0;
            lr_q     <= '0;
            clip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            acc_l_q  <= acc_l_d;
            acc_r_q  <= acc_r_d;
            strobe_q <= strobe_d;
            lr_q     <= lr_d;
            clip_q   <= clip_d;
        end
    end

    assign clk_sample = strobe_q;
    assign lrsample   = lr_q;
    assign clip       = clip_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_poly_mix_sampler.sv
// tb_poly_mix_sampler: directed stimulus, cycle-offset frame model,
// per-cycle output compare plus literal timing/value pins.
module tb_poly_mix_sampler;

    localparam int NV = 4;
    localparam int SD = 8;
    localparam int GW = 8;

    logic              clk = 1'b0;
    logic              aclr;
    logic              enable;
    logic [16*NV-1:0]  vs;
    logic [GW*NV-1:0]  vg;
    logic [2*NV-1:0]   vp;
    logic              clip_clr;
    logic              wrfull;
    logic              clk_sample;
    logic              wrreq;
    logic [63:0]       lrsample;
    logic              clip;
    logic              busy;

    poly_mix_sampler #(
        .NUM_VOICES(NV),
        .SAMPLE_DIV(SD),
        .GAIN_W(GW)
    ) dut (
        .clk(clk),
        .aclr(aclr),
        .enable(enable),
        .voice_sample(vs),
        .voice_gain(vg),
        .voice_pan(vp),
        .clip_clr(clip_clr),
        .wrfull(wrfull),
        .clk_sample(clk_sample),
        .wrreq(wrreq),
        .lrsample(lrsample),
        .clip(clip),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_strobe = 0;
    int n_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame model: a frame starts at strobe cycle T (offset k=0); voice i is
    // taken at offset i+1, the mix appears at offset NV+2, and the FIFO
    // write happens on the first cycle from there on with wrfull low.
    int           m_div = 0;
    bit           m_act = 0;
    int           m_k = 0;
    bit           m_strobe = 0;
    logic [15:0]  m_l = '0;
    logic [15:0]  m_r = '0;
    bit           m_clip = 0;
    longint       cs [NV];
    longint       cg [NV];
    logic [1:0]   cp [NV];

    function automatic bit clamps(input longint v);
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic model_step();
        bit     fire;
        bit     cl;
        bit     done;
        longint sl;
        longint sr;
        fire = enable && !wrfull && (m_div == SD - 1) && !m_act;
        if (m_act && m_k >= 1 && m_k <= NV) begin
            cs[m_k-1] = longint'($signed(vs[16*(m_k-1) +: 16]));
            cg[m_k-1] = longint'(vg[GW*(m_k-1) +: GW]);
            cp[m_k-1] = vp[2*(m_k-1) +: 2];
        end
        cl = 0;
        if (m_act && m_k == NV + 1) begin
            sl = 0;
            sr = 0;
            for (int i = 0; i < NV; i++) begin
                if (cp[i] == 2'b00 || cp[i] == 2'b01) sl += cs[i] * cg[i];
                if (cp[i] == 2'b00 || cp[i] == 2'b10) sr += cs[i] * cg[i];
            end
            sl = sl >>> GW;
            sr = sr >>> GW;
            cl = clamps(sl) || clamps(sr);
            m_l = sat16(sl);
            m_r = sat16(sr);
        end
        if (cl) m_clip = 1;
        else if (clip_clr) m_clip = 0;
        done = m_act && m_k >= NV + 2 && !wrfull;
        if (!enable || fire) m_div = 0;
        else if (!wrfull && m_div != SD - 1) m_div = m_div + 1;
        if (fire) begin
            m_act = 1;
            m_k = 0;
        end else if (done) begin
            m_act = 0;
        end else if (m_act) begin
            m_k = m_k + 1;
        end
        m_strobe = fire;
    endtask

    // Compare every cycle on the falling edge, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (aclr === 1'b1) begin
                m_div = 0;
                m_act = 0;
                m_k = 0;
                m_strobe = 0;
                m_l = '0;
                m_r = '0;
                m_clip = 0;
            end
            chk("clk_sample", 64'(clk_sample), 64'(m_strobe));
            chk("wrreq", 64'(wrreq),
                64'(m_act && m_k >= NV + 2 && !wrfull));
            chk("lrsample", lrsample, {16'h0, m_r, 16'h0, m_l});
            chk("clip", 64'(clip), 64'(m_clip));
            chk("busy", 64'(busy), 64'(m_act));
            if (clk_sample === 1'b1) n_strobe++;
            if (wrreq === 1'b1) n_wr++;
            if (aclr !== 1'b1) model_step();
        end
    end

    task automatic setv(input int i, input logic [15:0] s,
                        input logic [7:0] g, input logic [1:0] p);
        vs[16*i +: 16] = s;
        vg[GW*i +: GW] = g;
        vp[2*i +: 2]   = p;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string nm, output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (clk_sample === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no clk_sample within 60 cycles", nm);
        end
    endtask

    task automatic wait_wr(input string nm, output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wrreq === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no wrreq within 60 cycles", nm);
        end
    endtask

    int ts, tw, rel, s0, w0;

    initial begin
        aclr = 1'b1;
        enable = 1'b0;
        clip_clr = 1'b0;
        wrfull = 1'b0;
        vs = '0;
        vg = '0;
        vp = '1;
        setv(0, 16'h4000, 8'hFF, 2'b00);
        repeat (3) next_cyc();
        aclr = 1'b0;
        enable = 1'b1;

        // single centred voice
        wait_strobe("A_strobe", ts);
        wait_wr("A_wr", tw);
        chk("A_latency", 64'(tw - ts), 64'd6);
        chk("A_left", 64'(lrsample[15:0]), 64'h3FC0);
        chk("A_right", 64'(lrsample[47:32]), 64'h3FC0);
        chk("A_clip", 64'(clip), 64'd0);

        // positive overload
        next_cyc();
        for (int i = 0; i < NV; i++) setv(i, 16'h7FFF, 8'hFF, 2'b00);
        wait_strobe("B_strobe", ts);
        wait_wr("B_wr", tw);
        chk("B_word", lrsample, 64'h0000_7FFF_0000_7FFF);
        chk("B_clip", 64'(clip), 64'd1);

        // clear, then negative overload
        next_cyc();
        clip_clr = 1'b1;
        for (int i = 0; i < NV; i++) setv(i, 16'h8000, 8'hFF, 2'b00);
        next_cyc();
        clip_clr = 1'b0;
        @(negedge clk);
        chk("B_clip_clr", 64'(clip), 64'd0);
        wait_strobe("B2_strobe", ts);
        wait_wr("B2_wr", tw);
        chk("B2_word", lrsample, 64'h0000_8000_0000_8000);
        chk("B2_clip", 64'(clip), 64'd1);

        // hard-panned pair
        next_cyc();
        setv(0, 16'h1000, 8'h80, 2'b01);
        setv(1, 16'hF000, 8'h80, 2'b10);
        setv(2, 16'h7FFF, 8'hFF, 2'b11);
        setv(3, 16'h8000, 8'hFF, 2'b11);
        wait_strobe("C_strobe", ts);
        wait_wr("C_wr", tw);
        chk("C_word", lrsample, 64'h0000_F800_0000_0800);

        // FIFO full from T+5 for ten cycles
        wait_strobe("D_strobe", ts);
        repeat (5) next_cyc();
        wrfull = 1'b1;
        repeat (10) next_cyc();
        wrfull = 1'b0;
        wait_wr("D_wr", tw);
        chk("D_wr_offset", 64'(tw - ts), 64'd15);
        wait_strobe("D_next", rel);
        chk("D_strobe_offset", 64'(rel - ts), 64'd18);

        // free run: 96 cycles hold 12 strobes and 12 writes
        next_cyc();
        s0 = n_strobe;
        w0 = n_wr;
        repeat (96) next_cyc();
        chk("E_strobes", 64'(n_strobe - s0), 64'd12);
        chk("E_writes", 64'(n_wr - w0), 64'd12);

        // enable dropped mid-frame
        wait_strobe("E_strobe", ts);
        next_cyc();
        next_cyc();
        enable = 1'b0;
        wait_wr("E_wr", tw);
        chk("E_latency", 64'(tw - ts), 64'd6);
        s0 = n_strobe;
        repeat (30) next_cyc();
        chk("E_no_strobe", 64'(n_strobe - s0), 64'd0);

        // reset mid-accumulate
        enable = 1'b1;
        wait_strobe("F_strobe", ts);
        next_cyc();
        next_cyc();
        aclr = 1'b1;
        @(negedge clk);
        chk("F_busy", 64'(busy), 64'd0);
        chk("F_word", lrsample, 64'd0);
        chk("F_clip", 64'(clip), 64'd0);
        next_cyc();
        next_cyc();
        aclr = 1'b0;
        rel = cyc;
        w0 = n_wr;
        wait_strobe("F_restart", ts);
        chk("F_restart_gap", 64'(ts - rel), 64'(SD));
        chk("F_no_stale_wr", 64'(n_wr - w0), 64'd0);
        wait_wr("F_wr", tw);
        chk("F_latency", 64'(tw - ts), 64'd6);

        repeat (3) next_cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
